// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one memory bus port between the fetch and memory stages.
// Define RV32_MEM_ARB_RR_EN to replace fixed data-over-instr priority with round-robin ties.
package rv32_mem_arbiter_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } memory_request_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] data;
    } memory_response_t;

endpackage

module rv32_mem_arbiter
    import rv32_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_req_valid,
    input  memory_request_t  instr_request,
    output memory_response_t instr_response,
    input  logic             data_req_valid,
    input  memory_request_t  data_request,
    output memory_response_t data_response,
    output logic             mem_req_valid,
    output memory_request_t  mem_request,
    input  memory_response_t mem_response,
    output logic [1:0]       grant_owner,
    output logic             timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] OWNER_NONE  = 2'b00;
    localparam logic [1:0] OWNER_INSTR = 2'b01;
    localparam logic [1:0] OWNER_DATA  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               expired;
    logic               grant_instr;
    logic               grant_data;
    logic               txn_done;
    logic               data_wins_tie;
    memory_response_t   owner_resp;

`ifdef RV32_MEM_ARB_RR_EN
    logic [1:0] last_owner;

    // On a tie, serve whichever requester was not served by the last completed transaction.
    assign data_wins_tie = (last_owner == OWNER_INSTR);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWNER_INSTR;
        end else if (txn_done) begin
            last_owner <= grant_owner;
        end
    end
`else
    assign data_wins_tie = 1'b1;
`endif

    assign expired       = WDOG_EN && (wait_cnt == CNT_LIMIT);
    assign mem_req_valid = (state != IDLE);

    always_comb begin
        case (state)
            BUSY_I:  grant_owner = OWNER_INSTR;
            BUSY_D:  grant_owner = OWNER_DATA;
            default: grant_owner = OWNER_NONE;
        endcase
    end

    // Only the transaction owner ever sees ready; bus data wins over a coincident watchdog expiry.
    always_comb begin
        next_state     = state;
        grant_instr    = 1'b0;
        grant_data     = 1'b0;
        txn_done       = 1'b0;
        owner_resp     = '0;
        instr_response = '0;
        data_response  = '0;
        timeout        = 1'b0;

        case (state)
            IDLE: begin
                if (data_req_valid && (!instr_req_valid || data_wins_tie)) begin
                    grant_data = 1'b1;
                    next_state = BUSY_D;
                end else if (instr_req_valid) begin
                    grant_instr = 1'b1;
                    next_state  = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_response.ready || expired) begin
                    txn_done         = 1'b1;
                    next_state       = IDLE;
                    owner_resp.ready = 1'b1;
                    owner_resp.data  = mem_response.ready ? mem_response.data : ERR_DATA;
                    timeout          = !mem_response.ready;
                    if (state == BUSY_I) begin
                        instr_response = owner_resp;
                    end else begin
                        data_response = owner_resp;
                    end
                end
            end
            default: next_state = IDLE;
        endcase

        // A reset edge drops the in-flight transaction, so nothing is delivered that cycle.
        if (reset) begin
            instr_response = '0;
            data_response  = '0;
            timeout        = 1'b0;
            txn_done       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_request <= '0;
            wait_cnt    <= '0;
        end else begin
            state <= next_state;
            if (grant_data) begin
                mem_request <= data_request;
                wait_cnt    <= '0;
            end else if (grant_instr) begin
                mem_request <= instr_request;
                wait_cnt    <= '0;
            end else if (state != IDLE && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Testbench for rv32_mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_rv32_mem_arbiter;
    import rv32_mem_arbiter_pkg::*;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'h00000013;

    logic             clk = 1'b0;
    logic             reset;
    logic             instr_req_valid;
    memory_request_t  instr_request;
    memory_response_t instr_response;
    logic             data_req_valid;
    memory_request_t  data_request;
    memory_response_t data_response;
    logic             mem_req_valid;
    memory_request_t  mem_request;
    memory_response_t mem_response;
    logic [1:0]       grant_owner;
    logic             timeout;

    int n_checks = 0;
    int n_errors = 0;

    rv32_mem_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA(ERR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .instr_req_valid(instr_req_valid),
        .instr_request(instr_request),
        .instr_response(instr_response),
        .data_req_valid(data_req_valid),
        .data_request(data_request),
        .data_response(data_response),
        .mem_req_valid(mem_req_valid),
        .mem_request(mem_request),
        .mem_response(mem_response),
        .grant_owner(grant_owner),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic        mr;
        logic [31:0] md;
        int          e_mrv;
        int          e_own;
        int          e_ir;
        int          e_dr;
        logic [31:0] e_rdata;
        int          e_to;
        int          e_chk;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input int rst, input int iv, input logic [31:0] ia,
                                input int dv, input logic [31:0] da,
                                input int mr, input logic [31:0] md,
                                input int e_mrv, input int e_own, input int e_ir, input int e_dr,
                                input logic [31:0] e_rdata, input int e_to,
                                input int e_chk, input logic [31:0] e_addr);
        vec_t v;
        v.rst = (rst != 0);   v.iv = (iv != 0);   v.ia = ia;
        v.dv = (dv != 0);     v.da = da;
        v.mr = (mr != 0);     v.md = md;
        v.e_mrv = e_mrv;      v.e_own = e_own;    v.e_ir = e_ir;   v.e_dr = e_dr;
        v.e_rdata = e_rdata;  v.e_to = e_to;      v.e_chk = e_chk; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge and outputs are sampled shortly after, far from the rising edge.
    task automatic apply_stimulus(input logic rst, input logic iv, input logic [31:0] ia,
                                  input logic dv, input logic [31:0] da,
                                  input logic mr, input logic [31:0] md);
        @(negedge clk);
        reset           = rst;
        instr_req_valid = iv;
        instr_request   = '{addr: ia, wdata: 32'h0, we: 1'b0, be: 4'hF};
        data_req_valid  = dv;
        data_request    = '{addr: da, wdata: da ^ 32'h5A5A5A5A, we: da[2], be: 4'hF};
        mem_response    = '{ready: mr, data: md};
        #2;
    endtask

    task automatic check_output(input string tag, input int e_mrv, input int e_own,
                                input int e_ir, input int e_dr, input logic [31:0] e_rdata,
                                input int e_to, input int e_chk, input logic [31:0] e_addr);
        check_val($sformatf("%s.mem_req_valid", tag), 32'(mem_req_valid), 32'(e_mrv));
        check_val($sformatf("%s.grant_owner", tag), 32'(grant_owner), 32'(e_own));
        check_val($sformatf("%s.instr_ready", tag), 32'(instr_response.ready), 32'(e_ir));
        check_val($sformatf("%s.instr_data", tag), instr_response.data, (e_ir != 0) ? e_rdata : 32'h0);
        check_val($sformatf("%s.data_ready", tag), 32'(data_response.ready), 32'(e_dr));
        check_val($sformatf("%s.data_data", tag), data_response.data, (e_dr != 0) ? e_rdata : 32'h0);
        check_val($sformatf("%s.timeout", tag), 32'(timeout), 32'(e_to));
        if (e_chk != 0) begin
            check_val($sformatf("%s.mem_addr", tag), mem_request.addr, e_addr);
        end
    endtask

    // Reference model state: who owns the bus, how long it has waited, who was served last.
    int              m_owner;
    int              m_wait;
    int              m_last;
    memory_request_t m_req;
    logic            r_rst, r_iv, r_dv, r_mr;
    logic [31:0]     r_ia, r_da, r_md;

    initial begin
        int rr_mode;
        int exp_owner;
        int hit, exp_to;
        logic [31:0] exp_data;

`ifdef RV32_MEM_ARB_RR_EN
        rr_mode = 1;
`else
        rr_mode = 0;
`endif
        reset           = 1'b1;
        instr_req_valid = 1'b0;
        instr_request   = '0;
        data_req_valid  = 1'b0;
        data_request    = '0;
        mem_response    = '0;

        // Directed table: reset, single fetch, ready-while-idle, tie, reset mid-transaction.
        vecs[0]  = mk(1, 0, 0,        0, 0,         0, 0,             0, 0, 0, 0, 0,             0, 1, 0);
        vecs[1]  = mk(0, 1, 32'h100,  0, 0,         0, 0,             0, 0, 0, 0, 0,             0, 0, 0);
        vecs[2]  = mk(0, 1, 32'h100,  0, 0,         1, 32'hDEADBEEF,  1, 1, 1, 0, 32'hDEADBEEF,  0, 1, 32'h100);
        vecs[3]  = mk(0, 0, 0,        0, 0,         1, 32'h55,        0, 0, 0, 0, 0,             0, 0, 0);
        vecs[4]  = mk(0, 0, 0,        0, 0,         1, 32'h55,        0, 0, 0, 0, 0,             0, 0, 0);
        vecs[5]  = mk(0, 1, 32'h100,  1, 32'h2000,  0, 0,             0, 0, 0, 0, 0,             0, 0, 0);
        vecs[6]  = mk(0, 1, 32'h100,  1, 32'h2000,  0, 0,             1, 2, 0, 0, 0,             0, 1, 32'h2000);
        vecs[7]  = mk(0, 1, 32'h100,  1, 32'h2000,  1, 32'hCAFE0001,  1, 2, 0, 1, 32'hCAFE0001,  0, 1, 32'h2000);
        vecs[8]  = mk(0, 1, 32'h100,  0, 0,         0, 0,             0, 0, 0, 0, 0,             0, 0, 0);
        vecs[9]  = mk(0, 1, 32'h100,  0, 0,         1, 32'h11112222,  1, 1, 1, 0, 32'h11112222,  0, 1, 32'h100);
        vecs[10] = mk(0, 0, 0,        0, 0,         0, 0,             0, 0, 0, 0, 0,             0, 0, 0);
        vecs[11] = mk(0, 0, 0,        1, 32'h3000,  0, 0,             0, 0, 0, 0, 0,             0, 0, 0);
        vecs[12] = mk(0, 0, 0,        1, 32'h3000,  0, 0,             1, 2, 0, 0, 0,             0, 1, 32'h3000);
        vecs[13] = mk(1, 0, 0,        1, 32'h3000,  1, 32'h99,        1, 2, 0, 0, 0,             0, 1, 32'h3000);
        vecs[14] = mk(0, 0, 0,        0, 0,         1, 32'h77,        0, 0, 0, 0, 0,             0, 1, 0);

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da,
                           vecs[i].mr, vecs[i].md);
            check_output($sformatf("vec%0d", i), vecs[i].e_mrv, vecs[i].e_own, vecs[i].e_ir,
                         vecs[i].e_dr, vecs[i].e_rdata, vecs[i].e_to, vecs[i].e_chk, vecs[i].e_addr);
        end

        // Watchdog: bus never answers, so the fifth BUSY cycle (counter == TO) returns ERR.
        apply_stimulus(0, 0, 0, 1, 32'h4000, 0, 0);
        check_output("wd_req", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < TO; k++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, 0);
            check_output($sformatf("wd_wait%0d", k), 1, 2, 0, 0, 0, 0, 1, 32'h4000);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("wd_expire", 1, 2, 0, 1, ERR, 1, 1, 32'h4000);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("wd_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Bus ready on the expiry cycle: real data wins and no timeout pulse.
        apply_stimulus(0, 1, 32'h5000, 0, 0, 0, 0);
        check_output("wdr_req", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < TO; k++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, 0);
            check_output($sformatf("wdr_wait%0d", k), 1, 1, 0, 0, 0, 0, 1, 32'h5000);
        end
        apply_stimulus(0, 0, 0, 0, 0, 1, 32'hABCD0123);
        check_output("wdr_race", 1, 1, 1, 0, 32'hABCD0123, 0, 1, 32'h5000);

        // Continuous tie for four transactions from reset.
        apply_stimulus(1, 0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 4; t++) begin
            exp_owner = (rr_mode != 0 && (t % 2) == 1) ? 1 : 2;
            apply_stimulus(0, 1, 32'h600, 1, 32'h7000, 1, 32'h1000 + 32'(t));
            check_output($sformatf("tie%0d_idle", t), 0, 0, 0, 0, 0, 0, 0, 0);
            apply_stimulus(0, 1, 32'h600, 1, 32'h7000, 1, 32'h1000 + 32'(t));
            check_output($sformatf("tie%0d_busy", t), 1, exp_owner, (exp_owner == 1) ? 1 : 0,
                         (exp_owner == 2) ? 1 : 0, 32'h1000 + 32'(t), 0, 1,
                         (exp_owner == 1) ? 32'h600 : 32'h7000);
        end

        // Randomized run against the transaction-level model.
        m_owner = 0;
        m_wait  = 0;
        m_last  = 1;
        m_req   = '0;
        for (int i = 0; i < 2000; i++) begin
            r_rst = (i == 0) || ($urandom_range(0, 99) < 2);
            r_iv  = 1'($urandom_range(0, 1));
            r_dv  = 1'($urandom_range(0, 1));
            r_mr  = ($urandom_range(0, 99) < 30);
            r_ia  = $urandom & 32'hFFFF_FFFC;
            r_da  = $urandom;
            r_md  = $urandom;
            apply_stimulus(r_rst, r_iv, r_ia, r_dv, r_da, r_mr, r_md);

            hit      = (m_owner != 0 && !r_rst && (r_mr || m_wait == TO)) ? 1 : 0;
            exp_to   = (hit != 0 && !r_mr) ? 1 : 0;
            exp_data = r_mr ? r_md : ERR;
            check_output($sformatf("rnd%0d", i), (m_owner != 0) ? 1 : 0, m_owner,
                         (hit != 0 && m_owner == 1) ? 1 : 0, (hit != 0 && m_owner == 2) ? 1 : 0,
                         exp_data, exp_to, (m_owner != 0) ? 1 : 0, m_req.addr);
            if (m_owner != 0) begin
                check_val($sformatf("rnd%0d.mem_wdata", i), mem_request.wdata, m_req.wdata);
            end

            if (r_rst) begin
                m_owner = 0;
                m_wait  = 0;
                m_last  = 1;
                m_req   = '0;
            end else if (m_owner != 0) begin
                if (hit != 0) begin
                    m_last  = m_owner;
                    m_owner = 0;
                end else begin
                    m_wait++;
                end
            end else if (r_iv || r_dv) begin
                if (r_iv && r_dv) begin
                    m_owner = (rr_mode != 0 && m_last == 2) ? 1 : 2;
                end else begin
                    m_owner = r_dv ? 2 : 1;
                end
                m_req  = (m_owner == 2) ? data_request : instr_request;
                m_wait = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
